// File: rtl/clmul_pkg.sv
// Shared types and sizing for the sequential carry-less multiply unit.
// Optional build macro: CLMUL_EARLY_EXIT_EN (used by clmul_seq_unit).
package clmul_pkg;

  localparam int CLMUL_XLEN   = 32;
  localparam int CLMUL_BPC    = 4;
  localparam int CLMUL_TAG_W  = 5;
  localparam int CLMUL_CHUNKS = CLMUL_XLEN / CLMUL_BPC;

  typedef enum logic [1:0] {
    CLMUL  = 2'b00,
    CLMULH = 2'b01,
    CLMULR = 2'b10,
    RSVD   = 2'b11
  } clmul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } clmul_state_e;

  function automatic int n_chunks(input int xlen, input int bpc);
    return xlen / bpc;
  endfunction

endpackage

// File: rtl/clmul_if.sv
// Request/result bus between issue, the clmul unit and writeback.
// Handshake: a beat transfers on the rising edge where valid && ready; valid never waits on ready.
interface clmul_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rd;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_rd, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_rd, out_tag
  );
endinterface

// File: rtl/clmul_chunk_step.sv
// One accumulation step: XORs rs1, shifted to each set bit of the current rs2 chunk, into acc.
module clmul_chunk_step
  import clmul_pkg::*;
#(
  parameter int XLEN  = CLMUL_XLEN,
  parameter int B     = CLMUL_BPC,
  parameter int IDX_W = 3
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [B-1:0]      i_chunk,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_base;

  always_comb begin
    w_base = {{XLEN{1'b0}}, i_rs1} << (32'(i_idx) * B);
    o_acc  = i_acc;
    for (int j = 0; j < B; j++) begin
      if (i_chunk[j]) o_acc = o_acc ^ (w_base << j);
    end
  end

endmodule

// File: rtl/clmul_seq_unit.sv
// Multi-cycle clmul/clmulh/clmulr execute stage, BITS_PER_CYCLE rs2 bits per RUN cycle.
// Optional macro CLMUL_EARLY_EXIT_EN: finish as soon as the remaining rs2 bits are all zero.
module clmul_seq_unit
  import clmul_pkg::*;
#(
  parameter int XLEN           = CLMUL_XLEN,
  parameter int BITS_PER_CYCLE = CLMUL_BPC,
  parameter int TAG_W          = CLMUL_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  clmul_if.slave       bus,
  output logic         busy,
  output clmul_state_e o_dbg_state
);

  localparam int B        = BITS_PER_CYCLE;
  localparam int N_CHUNKS = n_chunks(XLEN, BITS_PER_CYCLE);
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  clmul_state_e      r_state, w_next;
  logic [XLEN-1:0]   r_rs1, r_rs2, r_rd;
  clmul_op_e         r_op;
  logic [TAG_W-1:0]  r_tag, r_out_tag;
  logic [2*XLEN-1:0] r_acc, w_acc_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [B-1:0]      w_chunk;
  logic              w_last, w_accept;
  logic [XLEN-1:0]   w_result;
  clmul_state_e      w_start_state;

`ifdef CLMUL_EARLY_EXIT_EN
  // rs2 is consumed from the bottom; once nothing is left above the chunk, we are done.
  logic [XLEN-1:0] w_rs2_rest;
  assign w_rs2_rest    = r_rs2 >> B;
  assign w_chunk       = r_rs2[B-1:0];
  assign w_last        = (w_rs2_rest == '0);
  assign w_start_state = (bus.in_rs2 == '0) ? DONE : RUN;
`else
  assign w_chunk       = B'(r_rs2 >> (32'(r_cnt) * B));
  assign w_last        = (r_cnt == CNT_W'(N_CHUNKS - 1));
  assign w_start_state = RUN;
`endif

  clmul_chunk_step #(
    .XLEN (XLEN),
    .B    (B),
    .IDX_W(CNT_W)
  ) u_step (
    .i_acc  (r_acc),
    .i_rs1  (r_rs1),
    .i_chunk(w_chunk),
    .i_idx  (r_cnt),
    .o_acc  (w_acc_next)
  );

  assign bus.in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_rd    = r_rd;
  assign bus.out_tag   = r_out_tag;
  assign busy          = (r_state == RUN) || (r_state == DONE);
  assign o_dbg_state   = r_state;
  assign w_accept      = bus.in_valid && bus.in_ready;

  always_comb begin
    w_result = '0;
    unique case (r_op)
      CLMUL:   w_result = w_acc_next[XLEN-1:0];
      CLMULH:  w_result = w_acc_next[2*XLEN-1:XLEN];
      CLMULR:  w_result = w_acc_next[2*XLEN-2:XLEN-1];
      default: w_result = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_next = w_start_state;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = bus.in_valid ? w_start_state : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_op      <= CLMUL;
      r_tag     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_out_tag <= '0;
    end else if (w_accept) begin
      r_rs1 <= bus.in_rs1;
      r_rs2 <= bus.in_rs2;
      r_op  <= clmul_op_e'(bus.in_op);
      r_tag <= bus.in_tag;
      r_acc <= '0;
      r_cnt <= '0;
`ifdef CLMUL_EARLY_EXIT_EN
      if (bus.in_rs2 == '0) begin
        r_rd      <= '0;
        r_out_tag <= bus.in_tag;
      end
`endif
    end else if (r_state == RUN) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
`ifdef CLMUL_EARLY_EXIT_EN
      r_rs2 <= w_rs2_rest;
`endif
      // Result is captured on the last step so out_rd/out_tag hold steady through DONE.
      if (w_last) begin
        r_rd      <= w_result;
        r_out_tag <= r_tag;
      end
    end
  end

endmodule

// File: tb/tb_clmul_seq_unit.sv
// Directed-vector bench for clmul_seq_unit with an expected-result queue and an output monitor.
module tb_clmul_seq_unit;
  import clmul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  clmul_state_e dbg_state;

  always #5 clk = ~clk;

  clmul_if #(.XLEN(32), .TAG_W(5)) bus ();

  clmul_seq_unit #(
    .XLEN          (32),
    .BITS_PER_CYCLE(4),
    .TAG_W         (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [36:0] exp_q[$];
  int lat_q[$];
  bit seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] rs2);
`ifdef CLMUL_EARLY_EXIT_EN
    int msb = -1;
    for (int i = 31; i >= 0; i--) begin
      if (rs2[i] && msb < 0) msb = i;
    end
    if (msb < 0) return 1;
    return 1 + (msb + 4) / 4;
`else
    if (rs2 === 32'hx) return 0;
    return 9;
`endif
  endfunction

  // Monitor: compares every presented result against the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 expected=0 (t=%0t)", $time);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency_cycle", cyc, lat_q[0]);
        end
        check("out_rd", bus.out_rd, exp_q[0][31:0]);
        check("out_tag", {27'b0, bus.out_tag}, {27'b0, exp_q[0][36:32]});
        check("busy_in_done", {31'b0, busy}, 32'd1);
        if (!bus.out_ready) check("in_ready_backpressure", {31'b0, bus.in_ready}, 32'd0);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    int n = 0;
    int a_cyc;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = tag;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d actual=in_ready_low expected=accept", tag);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_op    = 2'b00;
    bus.in_rs1   = $urandom();
    bus.in_rs2   = $urandom();
    exp_q.push_back({tag, exp});
    lat_q.push_back(a_cyc + exp_lat(b) - 1);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
      seen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  v_op  [11] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
  logic [31:0] v_rs1 [11] = '{32'h3, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h3, 32'h3, 32'hFFFFFFFF};
  logic [31:0] v_rs2 [11] = '{32'h3, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h0, 32'h5, 32'h2};
  logic [31:0] v_exp [11] = '{32'h5, 32'h0, 32'h40000000, 32'h80000000,
                              32'h55555555, 32'h55555555, 32'hAAAAAAAA, 32'h0,
                              32'h0, 32'hF, 32'h1};

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_rd", bus.out_rd, 32'd0);
    check("rst_out_tag", {27'b0, bus.out_tag}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      issue(v_op[i], v_rs1[i], v_rs2[i], 5'(i + 1), v_exp[i]);
      drain();
    end

    // Backpressure in DONE, then release together with a new request.
    bus.out_ready = 1'b0;
    issue(2'd0, 32'h0000000F, 32'h00000003, 5'd12, 32'h00000011);
    for (int n = 0; n < 100 && !bus.out_valid; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue(2'd0, 32'h3, 32'h3, 5'd13, 32'h5);
    drain();

    // Reset in the fourth RUN cycle aborts the operation.
    issue(2'd0, 32'h3, 32'hF0000003, 5'd15, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    lat_q.delete();
    seen = 1'b0;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_out_rd", bus.out_rd, 32'd0);
    check("midrst_out_tag", {27'b0, bus.out_tag}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("postrst_no_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(2'd0, 32'h3, 32'h3, 5'd16, 32'h5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
